// File: rtl/mpi_bus_pkg.sv
// Shared constants for the mpbuffer bus initiator: register offsets, module
// field position, FSM state encodings and the bus address builder.
package mpi_bus_pkg;

  localparam logic [12:0] OFS_DATA = 13'h0;
  localparam logic [12:0] OFS_LAST = 13'h4;
  localparam logic [12:0] OFS_SIZE = 13'h8;

  localparam int MOD_LSB = 13;
  localparam int MOD_MSB = 19;
  localparam int MOD_W   = MOD_MSB - MOD_LSB + 1;

  typedef logic [2:0] mpi_state_t;

  localparam mpi_state_t ST_PROBE = 3'd0;
  localparam mpi_state_t ST_IDLE  = 3'd1;
  localparam mpi_state_t ST_SEND  = 3'd2;
  localparam mpi_state_t ST_RSIZE = 3'd3;
  localparam mpi_state_t ST_RDATA = 3'd4;
  localparam mpi_state_t ST_DONE  = 3'd5;
  localparam mpi_state_t ST_ERROR = 3'd6;

  localparam logic [2:0] BACKOFF_CYC = 3'd4;

  function automatic logic [31:0] mk_addr(input logic [MOD_W-1:0] mod,
                                          input logic [12:0] ofs);
    mk_addr = '0;
    mk_addr[MOD_MSB:MOD_LSB] = mod;
    mk_addr[MOD_LSB-1:0] = ofs;
  endfunction

endpackage

// File: rtl/mpi_bus_access.sv
// Single bus access engine: owns bus_en/addr/we/data for one access, applies
// the ack/err handshake with a timeout, and reports done/err/rdata as pulses.
module mpi_bus_access
  import mpi_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic        o_bus_en,
  output logic [31:0] o_bus_data_out,
  input  logic [31:0] i_bus_data_in,
  input  logic        i_bus_ack,
  input  logic        i_bus_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic            r_en;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_done;
  logic            r_err;
  logic [TO_W-1:0] r_to;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_en) begin
        // err has priority over a simultaneous ack
        if (i_bus_err) begin
          r_en  <= 1'b0;
          r_err <= 1'b1;
          r_to  <= '0;
        end else if (i_bus_ack) begin
          r_en    <= 1'b0;
          r_done  <= 1'b1;
          r_rdata <= i_bus_data_in;
          r_to    <= '0;
        end else if (r_to == TO_LAST) begin
          r_en  <= 1'b0;
          r_err <= 1'b1;
          r_to  <= '0;
        end else begin
          r_to <= r_to + 1'b1;
        end
      end else if (i_start && !r_done && !r_err) begin
        r_en    <= 1'b1;
        r_addr  <= i_addr;
        r_we    <= i_we;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_rdata        = r_rdata;
  assign o_bus_en       = r_en;
  assign o_bus_we       = r_we & r_en;
  assign o_bus_addr     = r_addr;
  assign o_bus_data_out = r_wdata;

endmodule

// File: rtl/mpi_bus_initiator.sv
// Command FSM that turns send/receive requests into mpbuffer register accesses.
//   PROBE | read endpoint count from module 0 once after reset
//   IDLE  | accept a command
//   SEND  | push tx flits, last one to the close-packet offset
//   RSIZE | poll head packet size with backoff while empty
//   RDATA | pop flits, one outstanding until rx sink takes it
//   DONE  | done pulse
//   ERROR | error pulse
module mpi_bus_initiator
  import mpi_bus_pkg::*;
#(
  parameter int EP_WIDTH  = 7,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_write,
  input  logic [EP_WIDTH-1:0]  i_cmd_ep,
  input  logic [LEN_WIDTH-1:0] i_cmd_len,
  input  logic [31:0]          i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [31:0]          o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic [LEN_WIDTH-1:0] o_rx_len,
  output logic                 o_done,
  output logic                 o_error,
  output logic [31:0]          o_bus_addr,
  output logic                 o_bus_we,
  output logic                 o_bus_en,
  output logic [31:0]          o_bus_data_out,
  input  logic [31:0]          i_bus_data_in,
  input  logic                 i_bus_ack,
  input  logic                 i_bus_err
);

  mpi_state_t           r_state;
  logic [EP_WIDTH:0]    r_num_ep;
  logic [EP_WIDTH-1:0]  r_ep;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [LEN_WIDTH-1:0] r_rx_len;
  logic [31:0]          r_rx_data;
  logic                 r_rx_valid;
  logic                 r_wait;
  logic [2:0]           r_backoff;

  logic                 w_start;
  logic                 w_we;
  logic [31:0]          w_addr;
  logic [31:0]          w_wdata;
  logic                 w_tx_ready;
  logic                 w_acc_done;
  logic                 w_acc_err;
  logic [31:0]          w_acc_rdata;
  logic [MOD_W-1:0]     w_mod;
  logic                 w_size_ovf;
  logic [EP_WIDTH:0]    w_ep_cnt;

  assign w_mod      = MOD_W'(r_ep) + MOD_W'(1);
  assign w_size_ovf = |w_acc_rdata[31:LEN_WIDTH];
  // an endpoint count beyond what cmd_ep can address saturates
  assign w_ep_cnt   = (|w_acc_rdata[31:EP_WIDTH+1]) ? {1'b1, {EP_WIDTH{1'b0}}}
                                                    : w_acc_rdata[EP_WIDTH:0];

  always_comb begin
    w_start    = 1'b0;
    w_we       = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_tx_ready = 1'b0;
    case (r_state)
      ST_PROBE: begin
        if (!r_wait) begin
          w_start = 1'b1;
          w_addr  = mk_addr('0, OFS_DATA);
        end
      end
      ST_SEND: begin
        if (!r_wait && i_tx_valid) begin
          w_start    = 1'b1;
          w_we       = 1'b1;
          w_wdata    = i_tx_data;
          w_tx_ready = 1'b1;
          w_addr     = mk_addr(w_mod, (r_rem == LEN_WIDTH'(1)) ? OFS_LAST : OFS_DATA);
        end
      end
      ST_RSIZE: begin
        if (!r_wait && r_backoff == '0) begin
          w_start = 1'b1;
          w_addr  = mk_addr(w_mod, OFS_SIZE);
        end
      end
      ST_RDATA: begin
        if (!r_wait && !r_rx_valid) begin
          w_start = 1'b1;
          w_addr  = mk_addr(w_mod, OFS_DATA);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_PROBE;
      r_num_ep   <= '0;
      r_ep       <= '0;
      r_rem      <= '0;
      r_rx_len   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_wait     <= 1'b0;
      r_backoff  <= '0;
    end else begin
      if (w_start) r_wait <= 1'b1;
      else if (w_acc_done || w_acc_err) r_wait <= 1'b0;

      case (r_state)
        ST_PROBE: begin
          if (w_acc_err) r_state <= ST_ERROR;
          else if (w_acc_done) begin
            r_num_ep <= w_ep_cnt;
            r_state  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_ep      <= i_cmd_ep;
            r_rem     <= i_cmd_len;
            r_backoff <= '0;
            if (({1'b0, i_cmd_ep} >= r_num_ep) || (i_cmd_write && i_cmd_len == '0))
              r_state <= ST_ERROR;
            else if (i_cmd_write)
              r_state <= ST_SEND;
            else
              r_state <= ST_RSIZE;
          end
        end
        ST_SEND: begin
          if (w_acc_err) r_state <= ST_ERROR;
          else if (w_acc_done) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_WIDTH'(1)) r_state <= ST_DONE;
          end
        end
        ST_RSIZE: begin
          if (r_backoff != '0) r_backoff <= r_backoff - 1'b1;
          if (w_acc_err) r_state <= ST_ERROR;
          else if (w_acc_done) begin
            if (w_acc_rdata == '0) r_backoff <= BACKOFF_CYC;
            else if (w_size_ovf) r_state <= ST_ERROR;
            else begin
              r_rx_len <= w_acc_rdata[LEN_WIDTH-1:0];
              r_rem    <= w_acc_rdata[LEN_WIDTH-1:0];
              r_state  <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (w_acc_err) r_state <= ST_ERROR;
          else if (w_acc_done) begin
            r_rx_data  <= w_acc_rdata;
            r_rx_valid <= 1'b1;
          end else if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
            r_rem      <= r_rem - 1'b1;
            if (r_rem == LEN_WIDTH'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        ST_ERROR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  mpi_bus_access #(
    .TIMEOUT (TIMEOUT)
  ) u_access (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (w_start),
    .i_addr         (w_addr),
    .i_we           (w_we),
    .i_wdata        (w_wdata),
    .o_done         (w_acc_done),
    .o_err          (w_acc_err),
    .o_rdata        (w_acc_rdata),
    .o_bus_addr     (o_bus_addr),
    .o_bus_we       (o_bus_we),
    .o_bus_en       (o_bus_en),
    .o_bus_data_out (o_bus_data_out),
    .i_bus_data_in  (i_bus_data_in),
    .i_bus_ack      (i_bus_ack),
    .i_bus_err      (i_bus_err)
  );

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_tx_ready  = w_tx_ready;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_len    = r_rx_len;
  assign o_done      = (r_state == ST_DONE);
  assign o_error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_mpi_bus_initiator.sv
// Directed bench for mpi_bus_initiator with a behavioural mpbuffer slave that
// logs every completed access and serves reads from a response list.
module tb_mpi_bus_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_write = 1'b0;
  logic [6:0]  i_cmd_ep = '0;
  logic [7:0]  i_cmd_len = '0;
  logic [31:0] i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [31:0] o_rx_data;
  logic        o_rx_valid;
  logic        i_rx_ready = 1'b1;
  logic [7:0]  o_rx_len;
  logic        o_done;
  logic        o_error;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic        o_bus_en;
  logic [31:0] o_bus_data_out;
  logic [31:0] i_bus_data_in;
  logic        i_bus_ack;
  logic        i_bus_err;

  int n_checks = 0;
  int n_pass = 0;

  // slave / stream model state
  logic [31:0] rd_mem [64];
  logic [31:0] tx_mem [16];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  logic        log_we [256];
  int          log_cyc [256];
  logic [31:0] rx_log [64];
  int  tx_cnt = 0, tx_idx = 0, rd_ptr = 0, acc_cnt = 0, rx_cnt = 0;
  int  n_en = 0, n_done = 0, n_err = 0, n_txr = 0, cyc = 0;
  int  slv_err_at = -1;
  logic slv_hang = 1'b0;

  always #5 i_clk = ~i_clk;

  assign i_tx_valid    = (tx_idx < tx_cnt);
  assign i_tx_data     = tx_mem[tx_idx[3:0]];
  assign i_bus_data_in = rd_mem[rd_ptr[5:0]];
  assign i_bus_ack     = o_bus_en & ~slv_hang;
  assign i_bus_err     = o_bus_en & (acc_cnt == slv_err_at);

  mpi_bus_initiator dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_write    (i_cmd_write),
    .i_cmd_ep       (i_cmd_ep),
    .i_cmd_len      (i_cmd_len),
    .i_tx_data      (i_tx_data),
    .i_tx_valid     (i_tx_valid),
    .o_tx_ready     (o_tx_ready),
    .o_rx_data      (o_rx_data),
    .o_rx_valid     (o_rx_valid),
    .i_rx_ready     (i_rx_ready),
    .o_rx_len       (o_rx_len),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_bus_addr     (o_bus_addr),
    .o_bus_we       (o_bus_we),
    .o_bus_en       (o_bus_en),
    .o_bus_data_out (o_bus_data_out),
    .i_bus_data_in  (i_bus_data_in),
    .i_bus_ack      (i_bus_ack),
    .i_bus_err      (i_bus_err)
  );

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_bus_en) n_en <= n_en + 1;
    if (o_done) n_done <= n_done + 1;
    if (o_error) n_err <= n_err + 1;
    if (o_tx_ready && i_tx_valid) begin
      n_txr  <= n_txr + 1;
      tx_idx <= tx_idx + 1;
    end
    if (o_rx_valid && i_rx_ready) begin
      rx_log[rx_cnt[5:0]] <= o_rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (o_bus_en && (i_bus_ack || i_bus_err)) begin
      log_addr[acc_cnt[7:0]] <= o_bus_addr;
      log_data[acc_cnt[7:0]] <= o_bus_data_out;
      log_we[acc_cnt[7:0]]   <= o_bus_we;
      log_cyc[acc_cnt[7:0]]  <= cyc;
      acc_cnt <= acc_cnt + 1;
      if (!i_bus_err && !o_bus_we) rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_cmd(input logic wr, input logic [6:0] ep, input logic [7:0] len);
    i_cmd_write = wr;
    i_cmd_ep    = ep;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !o_cmd_ready; k++) @(negedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int max);
    for (int k = 0; k < max && n_done == d0 && n_err == e0; k++) @(negedge i_clk);
    tick(3);
  endtask

  task automatic test_reset;
    #1 i_rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({o_cmd_ready, o_tx_ready, o_rx_valid, o_done, o_error, o_bus_en, o_bus_we} !== 7'b0)
      $display("FAIL reset_ctrl got %b exp 0000000",
               {o_cmd_ready, o_tx_ready, o_rx_valid, o_done, o_error, o_bus_en, o_bus_we});
    else n_pass++;
    n_checks++;
    if ({o_bus_addr, o_bus_data_out, o_rx_data, o_rx_len} !== 104'b0)
      $display("FAIL reset_data got %h %h %h %h exp zeros", o_bus_addr, o_bus_data_out, o_rx_data, o_rx_len);
    else n_pass++;
    i_rst_n = 1'b1;
    for (int k = 0; k < 30 && !o_cmd_ready; k++) @(negedge i_clk);
    tick(2);
    n_checks++;
    if (acc_cnt !== 1) $display("FAIL probe_count got %0d exp 1", acc_cnt);
    else n_pass++;
    n_checks++;
    if ({log_we[0], log_addr[0]} !== {1'b0, 32'h0})
      $display("FAIL probe_access got we=%b addr=%h exp we=0 addr=00000000", log_we[0], log_addr[0]);
    else n_pass++;
    n_checks++;
    if (o_cmd_ready !== 1'b1) $display("FAIL probe_ready got %b exp 1", o_cmd_ready);
    else n_pass++;
  endtask

  task automatic test_send;
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    logic [7:0]  ix;
    int a0, d0, e0, t0;
    exp_a = '{32'h0000_4000, 32'h0000_4000, 32'h0000_4004};
    exp_d = '{32'hA1, 32'hA2, 32'hA3};
    a0 = acc_cnt; d0 = n_done; e0 = n_err; t0 = n_txr;
    for (int k = 0; k < 3; k++) tx_mem[4'(tx_cnt + k)] = exp_d[k];
    tx_cnt = tx_cnt + 3;
    do_cmd(1'b1, 7'd1, 8'd3);
    wait_end(d0, e0, 200);
    n_checks++;
    if (acc_cnt - a0 !== 3) $display("FAIL send_naccess got %0d exp 3", acc_cnt - a0);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      ix = 8'(a0 + k);
      n_checks++;
      if ({log_we[ix], log_addr[ix], log_data[ix]} !== {1'b1, exp_a[k], exp_d[k]})
        $display("FAIL send_write%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                 k, log_we[ix], log_addr[ix], log_data[ix], exp_a[k], exp_d[k]);
      else n_pass++;
    end
    n_checks++;
    if (n_txr - t0 !== 3) $display("FAIL send_txready got %0d exp 3", n_txr - t0);
    else n_pass++;
    n_checks++;
    if ({n_done - d0, n_err - e0} !== {32'd1, 32'd0})
      $display("FAIL send_pulses got done=%0d err=%0d exp done=1 err=0", n_done - d0, n_err - e0);
    else n_pass++;
  endtask

  task automatic test_receive;
    logic [5:0]  p;
    logic [31:0] exp_a [5];
    logic [7:0]  ix;
    int a0, d0, e0, r0, gap;
    exp_a = '{32'h2008, 32'h2008, 32'h2008, 32'h2000, 32'h2000};
    p = rd_ptr[5:0];
    rd_mem[p] = 32'd0; rd_mem[p + 6'd1] = 32'd0; rd_mem[p + 6'd2] = 32'd2;
    rd_mem[p + 6'd3] = 32'h11; rd_mem[p + 6'd4] = 32'h22;
    a0 = acc_cnt; d0 = n_done; e0 = n_err; r0 = rx_cnt;
    i_rx_ready = 1'b1;
    do_cmd(1'b0, 7'd0, 8'd0);
    wait_end(d0, e0, 300);
    n_checks++;
    if (acc_cnt - a0 !== 5) $display("FAIL recv_naccess got %0d exp 5", acc_cnt - a0);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      ix = 8'(a0 + k);
      n_checks++;
      if ({log_we[ix], log_addr[ix]} !== {1'b0, exp_a[k]})
        $display("FAIL recv_read%0d got we=%b addr=%h exp we=0 addr=%h", k, log_we[ix], log_addr[ix], exp_a[k]);
      else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      gap = log_cyc[8'(a0 + k + 1)] - log_cyc[8'(a0 + k)];
      n_checks++;
      if (gap < 5) $display("FAIL recv_poll_gap%0d got %0d exp >=5", k, gap);
      else n_pass++;
    end
    n_checks++;
    if (o_rx_len !== 8'd2) $display("FAIL recv_rxlen got %0d exp 2", o_rx_len);
    else n_pass++;
    n_checks++;
    if ({rx_cnt - r0, rx_log[r0[5:0]], rx_log[6'(r0 + 1)]} !== {32'd2, 32'h11, 32'h22})
      $display("FAIL recv_rxdata got n=%0d %h %h exp n=2 00000011 00000022",
               rx_cnt - r0, rx_log[r0[5:0]], rx_log[6'(r0 + 1)]);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL recv_done got %0d exp 1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_rx_stall;
    logic [5:0] p;
    int a0, d0, e0, r0, en0, held;
    p = rd_ptr[5:0];
    rd_mem[p] = 32'd2; rd_mem[p + 6'd1] = 32'h33; rd_mem[p + 6'd2] = 32'h44;
    a0 = acc_cnt; d0 = n_done; e0 = n_err; r0 = rx_cnt;
    i_rx_ready = 1'b0;
    do_cmd(1'b0, 7'd1, 8'd0);
    for (int k = 0; k < 100 && !o_rx_valid; k++) @(negedge i_clk);
    en0 = n_en;
    held = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (o_rx_valid === 1'b1 && o_rx_data === 32'h33) held++;
    end
    n_checks++;
    if (held !== 10) $display("FAIL stall_hold got %0d exp 10", held);
    else n_pass++;
    n_checks++;
    if (n_en - en0 !== 0) $display("FAIL stall_bus_idle got %0d exp 0", n_en - en0);
    else n_pass++;
    i_rx_ready = 1'b1;
    wait_end(d0, e0, 200);
    n_checks++;
    if ({rx_cnt - r0, rx_log[r0[5:0]], rx_log[6'(r0 + 1)]} !== {32'd2, 32'h33, 32'h44})
      $display("FAIL stall_rxdata got n=%0d %h %h exp n=2 00000033 00000044",
               rx_cnt - r0, rx_log[r0[5:0]], rx_log[6'(r0 + 1)]);
    else n_pass++;
    n_checks++;
    if ({acc_cnt - a0, log_addr[a0[7:0]], log_addr[8'(a0 + 2)]} !== {32'd3, 32'h4008, 32'h4000})
      $display("FAIL stall_access got n=%0d %h %h exp n=3 00004008 00004000",
               acc_cnt - a0, log_addr[a0[7:0]], log_addr[8'(a0 + 2)]);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL stall_done got %0d exp 1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_bus_err;
    int a0, d0, e0, t0;
    a0 = acc_cnt; d0 = n_done; e0 = n_err; t0 = n_txr;
    tx_mem[4'(tx_cnt)] = 32'hB1; tx_mem[4'(tx_cnt + 1)] = 32'hB2; tx_mem[4'(tx_cnt + 2)] = 32'hB3;
    tx_cnt = tx_cnt + 3;
    slv_err_at = a0 + 1;
    do_cmd(1'b1, 7'd0, 8'd3);
    wait_end(d0, e0, 200);
    tick(3);
    n_checks++;
    if ({n_err - e0, n_done - d0} !== {32'd1, 32'd0})
      $display("FAIL buserr_pulses got err=%0d done=%0d exp err=1 done=0", n_err - e0, n_done - d0);
    else n_pass++;
    n_checks++;
    if ({acc_cnt - a0, log_addr[8'(a0 + 1)], log_data[8'(a0 + 1)]} !== {32'd2, 32'h2000, 32'hB2})
      $display("FAIL buserr_access got n=%0d %h %h exp n=2 00002000 000000b2",
               acc_cnt - a0, log_addr[8'(a0 + 1)], log_data[8'(a0 + 1)]);
    else n_pass++;
    n_checks++;
    if (n_txr - t0 !== 2) $display("FAIL buserr_txready got %0d exp 2", n_txr - t0);
    else n_pass++;
    n_checks++;
    if (o_cmd_ready !== 1'b1) $display("FAIL buserr_idle got %b exp 1", o_cmd_ready);
    else n_pass++;
    slv_err_at = -1;
    tx_cnt = tx_idx;
    a0 = acc_cnt; d0 = n_done; e0 = n_err;
    tx_mem[4'(tx_cnt)] = 32'hC1;
    tx_cnt = tx_cnt + 1;
    do_cmd(1'b1, 7'd1, 8'd1);
    wait_end(d0, e0, 200);
    n_checks++;
    if ({acc_cnt - a0, log_addr[a0[7:0]], log_data[a0[7:0]], n_done - d0} !==
        {32'd1, 32'h4004, 32'hC1, 32'd1})
      $display("FAIL buserr_recover got n=%0d %h %h done=%0d exp n=1 00004004 000000c1 done=1",
               acc_cnt - a0, log_addr[a0[7:0]], log_data[a0[7:0]], n_done - d0);
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic [5:0] p;
    int d0, e0, en0, r0;
    d0 = n_done; e0 = n_err; en0 = n_en;
    slv_hang = 1'b1;
    do_cmd(1'b0, 7'd0, 8'd0);
    wait_end(d0, e0, 600);
    n_checks++;
    if (n_en - en0 !== 255) $display("FAIL timeout_en_cycles got %0d exp 255", n_en - en0);
    else n_pass++;
    n_checks++;
    if ({n_err - e0, n_done - d0} !== {32'd1, 32'd0})
      $display("FAIL timeout_pulses got err=%0d done=%0d exp err=1 done=0", n_err - e0, n_done - d0);
    else n_pass++;
    slv_hang = 1'b0;
    n_checks++;
    if ({o_cmd_ready, o_bus_en} !== 2'b10)
      $display("FAIL timeout_idle got ready=%b en=%b exp ready=1 en=0", o_cmd_ready, o_bus_en);
    else n_pass++;
    p = rd_ptr[5:0];
    rd_mem[p] = 32'd1; rd_mem[p + 6'd1] = 32'h55;
    d0 = n_done; e0 = n_err; r0 = rx_cnt;
    do_cmd(1'b0, 7'd0, 8'd0);
    wait_end(d0, e0, 200);
    n_checks++;
    if ({rx_cnt - r0, rx_log[r0[5:0]], n_done - d0} !== {32'd1, 32'h55, 32'd1})
      $display("FAIL timeout_recover got n=%0d %h done=%0d exp n=1 00000055 done=1",
               rx_cnt - r0, rx_log[r0[5:0]], n_done - d0);
    else n_pass++;
  endtask

  task automatic test_bad_cmd;
    int a0, d0, e0, t0;
    a0 = acc_cnt; d0 = n_done; e0 = n_err; t0 = n_txr;
    do_cmd(1'b0, 7'd2, 8'd1);
    tick(4);
    n_checks++;
    if ({n_err - e0, acc_cnt - a0, n_en} !== {32'd1, 32'd0, n_en} || o_cmd_ready !== 1'b1)
      $display("FAIL badep got err=%0d acc=%0d ready=%b exp err=1 acc=0 ready=1",
               n_err - e0, acc_cnt - a0, o_cmd_ready);
    else n_pass++;
    do_cmd(1'b1, 7'd0, 8'd0);
    tick(4);
    n_checks++;
    if ({n_err - e0, acc_cnt - a0, n_done - d0, n_txr - t0} !== {32'd2, 32'd0, 32'd0, 32'd0})
      $display("FAIL zerolen got err=%0d acc=%0d done=%0d tx=%0d exp err=2 acc=0 done=0 tx=0",
               n_err - e0, acc_cnt - a0, n_done - d0, n_txr - t0);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rd_mem[i] = '0;
    for (int i = 0; i < 16; i++) tx_mem[i] = '0;
    rd_mem[0] = 32'd2;
    test_reset();
    test_send();
    test_receive();
    test_rx_stall();
    test_bus_err();
    test_timeout();
    test_bad_cmd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
